// File: rtl/vending_pkg.sv
// Shared definitions for the coin payout path: coin values, FSM states and coin-select encoding.
package vending_pkg;

    localparam int NICKEL_C  = 5;
    localparam int DIME_C    = 10;
    localparam int QUARTER_C = 25;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'd0,
        COIN_NICKEL  = 2'd1,
        COIN_DIME    = 2'd2,
        COIN_QUARTER = 2'd3
    } coin_t;

endpackage

// File: rtl/coin_pulse_timer.sv
// Loadable down-counter timing the PULSE and GAP phases; expired is high once the count reaches zero.
module coin_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy change payout engine: turns a cent amount into quarter/dime/nickel hopper pulses
// against a finite per-denomination inventory and reports any unpaid remainder.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMT_W     = 9,
    parameter int CNT_W     = 8,
    parameter int N_INIT    = 20,
    parameter int D_INIT    = 20,
    parameter int Q_INIT    = 20,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             load_inv,
    input  logic [CNT_W-1:0] load_n,
    input  logic [CNT_W-1:0] load_d,
    input  logic [CNT_W-1:0] load_q,
    output logic             busy,
    output logic             done,
    output logic [AMT_W-1:0] short_amt,
    output logic             nickel_out,
    output logic             dime_out,
    output logic             quarter_out,
    output logic [CNT_W-1:0] n_cnt,
    output logic [CNT_W-1:0] d_cnt,
    output logic [CNT_W-1:0] q_cnt,
    output state_t           dbg_state
);

    localparam int TW = 8;
    localparam logic [AMT_W-1:0] NV = AMT_W'(NICKEL_C);
    localparam logic [AMT_W-1:0] DV = AMT_W'(DIME_C);
    localparam logic [AMT_W-1:0] QV = AMT_W'(QUARTER_C);

    state_t           state, state_d;
    coin_t            sel, sel_d, pick;
    logic [AMT_W-1:0] remaining;
    logic [2:0]       residue;
    logic [AMT_W-1:0] amt_mod;
    logic             timer_load;
    logic [TW-1:0]    timer_val;
    logic             timer_expired;

    assign amt_mod   = amount % NV;
    assign dbg_state = state;

    coin_pulse_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .expired  (timer_expired)
    );

    // Largest coin first; an empty hopper is skipped so counters never wrap.
    always_comb begin
        pick = COIN_NONE;
        if (remaining >= QV && q_cnt != '0) begin
            pick = COIN_QUARTER;
        end else if (remaining >= DV && d_cnt != '0) begin
            pick = COIN_DIME;
        end else if (remaining >= NV && n_cnt != '0) begin
            pick = COIN_NICKEL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            sel   <= COIN_NONE;
        end else begin
            state <= state_d;
            sel   <= sel_d;
        end
    end

    always_comb begin
        state_d    = state;
        sel_d      = sel;
        timer_load = 1'b0;
        timer_val  = '0;
        case (state)
            ST_IDLE: begin
                if (start) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (pick != COIN_NONE) begin
                    sel_d      = pick;
                    state_d    = ST_PULSE;
                    timer_load = 1'b1;
                    timer_val  = TW'(PULSE_LEN - 1);
                end else begin
                    sel_d   = COIN_NONE;
                    state_d = ST_DONE;
                end
            end
            ST_PULSE: begin
                if (timer_expired) begin
                    state_d    = ST_GAP;
                    timer_load = 1'b1;
                    timer_val  = TW'(GAP_LEN - 1);
                end
            end
            ST_GAP: begin
                if (timer_expired) state_d = ST_SELECT;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath: amount capture, inventory and remainder bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            residue   <= '0;
            short_amt <= '0;
            n_cnt     <= CNT_W'(N_INIT);
            d_cnt     <= CNT_W'(D_INIT);
            q_cnt     <= CNT_W'(Q_INIT);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= amount - amt_mod;
                        residue   <= amt_mod[2:0];
                        short_amt <= '0;
                    end else if (load_inv) begin
                        n_cnt <= load_n;
                        d_cnt <= load_d;
                        q_cnt <= load_q;
                    end
                end
                ST_SELECT: begin
                    case (pick)
                        COIN_QUARTER: begin
                            q_cnt     <= q_cnt - 1'b1;
                            remaining <= remaining - QV;
                        end
                        COIN_DIME: begin
                            d_cnt     <= d_cnt - 1'b1;
                            remaining <= remaining - DV;
                        end
                        COIN_NICKEL: begin
                            n_cnt     <= n_cnt - 1'b1;
                            remaining <= remaining - NV;
                        end
                        default: begin
                            short_amt <= remaining + AMT_W'(residue);
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Outputs registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            nickel_out  <= 1'b0;
            dime_out    <= 1'b0;
            quarter_out <= 1'b0;
        end else begin
            busy        <= (state_d == ST_SELECT) || (state_d == ST_PULSE) || (state_d == ST_GAP);
            done        <= (state_d == ST_DONE);
            nickel_out  <= (state_d == ST_PULSE) && (sel_d == COIN_NICKEL);
            dime_out    <= (state_d == ST_PULSE) && (sel_d == COIN_DIME);
            quarter_out <= (state_d == ST_PULSE) && (sel_d == COIN_QUARTER);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, pulse timing, inventory and shortfall reporting.
module tb_change_dispenser;
    import vending_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [8:0] amount;
    logic       load_inv;
    logic [7:0] load_n, load_d, load_q;
    logic       busy, done;
    logic [8:0] short_amt;
    logic       nickel_out, dime_out, quarter_out;
    logic [7:0] n_cnt, d_cnt, q_cnt;
    state_t     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];

    change_dispenser dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .amount      (amount),
        .load_inv    (load_inv),
        .load_n      (load_n),
        .load_d      (load_d),
        .load_q      (load_q),
        .busy        (busy),
        .done        (done),
        .short_amt   (short_amt),
        .nickel_out  (nickel_out),
        .dime_out    (dime_out),
        .quarter_out (quarter_out),
        .n_cnt       (n_cnt),
        .d_cnt       (d_cnt),
        .q_cnt       (q_cnt),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_counts(input string tag, input int n, input int d, input int q);
        check({tag, "_n_cnt"}, n_cnt, n);
        check({tag, "_d_cnt"}, d_cnt, d);
        check({tag, "_q_cnt"}, q_cnt, q);
    endtask

    task automatic load_inventory(input int n, input int d, input int q);
        load_n = 8'(n); load_d = 8'(d); load_q = 8'(q);
        load_inv = 1'b1;
        tick();
        load_inv = 1'b0;
        check_counts("load", n, d, q);
    endtask

    // Coin codes: 1 nickel, 2 dime, 3 quarter. exp_q holds the expected coin order.
    task automatic run_payout(input string tag, input int amt, input int inject_cyc,
                              input int exp_done, input int exp_short);
        int c, done_c, first_c, run;
        logic [2:0] cur, prev;
        logic multi, width_bad;
        amount = 9'(amt);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        c = 0; done_c = -1; first_c = -1; run = 0;
        prev = '0; multi = 1'b0; width_bad = 1'b0;
        obs_q.delete();
        while (done_c < 0 && c < 200) begin
            tick();
            c++;
            if (c == inject_cyc) begin
                start = 1'b1; load_inv = 1'b1; amount = 9'd25;
                load_n = 8'd0; load_d = 8'd0; load_q = 8'd0;
            end else if (c == inject_cyc + 1) begin
                start = 1'b0; load_inv = 1'b0;
            end
            cur = {quarter_out, dime_out, nickel_out};
            if ($countones(cur) > 1) multi = 1'b1;
            if (cur != 3'b000 && prev == 3'b000) begin
                obs_q.push_back(cur[2] ? 2'd3 : (cur[1] ? 2'd2 : 2'd1));
                if (first_c < 0) first_c = c;
                run = 0;
            end
            if (cur != 3'b000) run++;
            if (cur == 3'b000 && prev != 3'b000 && run != 2) width_bad = 1'b1;
            prev = cur;
            if (done) done_c = c;
        end
        check({tag, "_done_cycle"}, done_c, exp_done);
        check({tag, "_short_amt"}, short_amt, exp_short);
        check({tag, "_one_coin_at_a_time"}, multi, 0);
        check({tag, "_pulse_width"}, width_bad, 0);
        check({tag, "_first_coin_cycle"}, first_c, (exp_q.size() > 0) ? 1 : -1);
        check({tag, "_coin_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_coin%0d", tag, i), (i < obs_q.size()) ? obs_q[i] : 2'd0, exp_q[i]);
        end
        exp_q.delete();
        tick();
        check({tag, "_done_one_cycle"}, done, 0);
        check({tag, "_busy_cleared"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; amount = '0; load_inv = 1'b0;
        load_n = '0; load_d = '0; load_q = '0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_short", short_amt, 0);
        check("rst_coins", {quarter_out, dime_out, nickel_out}, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check_counts("rst", 20, 20, 20);
        #2 reset = 1'b0;
        tick();

        // 40c from full inventory: quarter, dime, nickel.
        exp_q.push_back(2'd3); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        run_payout("t1_40c", 40, -5, 16, 0);
        check_counts("t1", 19, 19, 19);

        // Limited inventory, greedy leaves 5c unpaid.
        load_inventory(1, 2, 0);
        exp_q.push_back(2'd2); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        run_payout("t2_30c", 30, -5, 16, 5);
        check_counts("t2", 0, 0, 0);

        // Residue below a nickel is reported short.
        load_inventory(5, 5, 5);
        exp_q.push_back(2'd3); exp_q.push_back(2'd2);
        run_payout("t3_37c", 37, -5, 11, 2);
        check_counts("t3", 5, 4, 4);

        // Zero amount: straight to DONE.
        run_payout("t4_0c", 0, -5, 1, 0);
        check_counts("t4", 5, 4, 4);

        // start and load_inv during PULSE must be ignored.
        exp_q.push_back(2'd2); exp_q.push_back(2'd1);
        run_payout("t5_15c", 15, 1, 11, 0);
        check_counts("t5", 4, 3, 4);
        exp_q.push_back(2'd1);
        run_payout("t5_follow_5c", 5, -5, 6, 0);
        check_counts("t5_follow", 3, 3, 4);

        // Reset mid-PULSE of a 50c payout.
        amount = 9'd50;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        check("t6_quarter_in_flight", quarter_out, 1);
        check("t6_q_decremented", q_cnt, 3);
        #2 reset = 1'b1;
        #1;
        check("t6_async_quarter", quarter_out, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_state", dbg_state, ST_IDLE);
        check_counts("t6_async", 20, 20, 20);
        #2 reset = 1'b0;
        tick();
        exp_q.push_back(2'd3); exp_q.push_back(2'd3);
        run_payout("t6_after_50c", 50, -5, 11, 0);
        check_counts("t6_after", 20, 20, 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
